// File: rtl/spi_responder_if.sv
// Pin and handshake bundle for spi_responder: SPI pins plus the tx holding
// register handshake and the received-byte strobe.
interface spi_responder_if;
   logic       i_cs_n;
   logic       i_sclk;
   logic       i_mosi;
   logic       o_miso;
   logic [7:0] i_tx_data;
   logic       i_tx_valid;
   logic       o_tx_ready;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       o_busy;

   modport slave (
      input  i_cs_n, i_sclk, i_mosi, i_tx_data, i_tx_valid,
      output o_miso, o_tx_ready, o_rx_data, o_rx_valid, o_busy
   );

   modport master (
      output i_cs_n, i_sclk, i_mosi, i_tx_data, i_tx_valid,
      input  o_miso, o_tx_ready, o_rx_data, o_rx_valid, o_busy
   );
endinterface

// File: rtl/spi_responder.sv
// Mode-0 SPI responder oversampling SCLK/CS_N/MOSI on i_clk, MSB-first both ways.
// Optional macro SPI_RESPONDER_UNDERRUN_EN adds o_underrun (load took IDLE_FILL).
module spi_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
   input  logic           i_clk,
   input  logic           i_rst,
   spi_responder_if.slave io_bus
`ifdef SPI_RESPONDER_UNDERRUN_EN
   ,
   output logic           o_underrun
`endif
);
   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_prev;
   logic [2:0]             r_cnt;
   logic                   r_rx_done;
   logic                   r_tx_ready;
   logic                   r_miso;
   logic                   r_rx_valid;
   logic [7:0]             r_rx_data;
   logic [7:0]             r_rx;
   logic [7:0]             r_tx;
   logic [7:0]             r_hold;

   logic       w_cs_n;
   logic       w_sclk;
   logic       w_mosi;
   logic       w_rise;
   logic       w_fall;
   logic       w_active;
   logic       w_load;
   logic       w_accept;
   logic       w_shift_rx;
   logic       w_shift_tx;
   logic [7:0] w_load_data;

   assign w_cs_n   = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
   assign w_rise   = w_sclk && !r_sclk_prev;
   assign w_fall   = !w_sclk && r_sclk_prev;
   // A CS_N rise masks any SCLK edge seen in the same cycle.
   assign w_active   = (r_state == S_ACTIVE) && !w_cs_n;
   assign w_shift_rx = w_active && w_rise;
   assign w_shift_tx = w_active && w_fall && (r_cnt != 3'd0);
   assign w_load     = ((r_state == S_IDLE) && !w_cs_n) ||
                       (w_active && w_fall && (r_cnt == 3'd0));
   assign w_accept    = io_bus.i_tx_valid && r_tx_ready;
   assign w_load_data = r_tx_ready ? IDLE_FILL : r_hold;

   assign io_bus.o_miso     = r_miso;
   assign io_bus.o_tx_ready = r_tx_ready;
   assign io_bus.o_rx_data  = r_rx_data;
   assign io_bus.o_rx_valid = r_rx_valid;
   assign io_bus.o_busy     = !w_cs_n;

`ifdef SPI_RESPONDER_UNDERRUN_EN
   assign o_underrun = i_rst && w_load && r_tx_ready;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_rx_done   <= 1'b0;
         r_tx_ready  <= 1'b1;
         r_miso      <= 1'b1;
         r_rx_valid  <= 1'b0;
         r_rx_data   <= 8'h00;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], io_bus.i_cs_n};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_bus.i_sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_bus.i_mosi};
         r_sclk_prev <= w_sclk;
         r_miso      <= (r_state == S_ACTIVE) ? r_tx[7] : 1'b1;
         // Completed byte is published one cycle after the wrapping rise.
         r_rx_valid  <= r_rx_done;
         r_rx_done   <= 1'b0;
         if (r_rx_done)
            r_rx_data <= r_rx;
         if (w_accept)
            r_tx_ready <= 1'b0;
         else if (w_load && !r_tx_ready)
            r_tx_ready <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_cnt <= 3'd0;
               if (!w_cs_n)
                  r_state <= S_ACTIVE;
            end
            default: begin
               if (w_cs_n) begin
                  r_state <= S_IDLE;
                  r_cnt   <= 3'd0;
               end else if (w_rise) begin
                  r_cnt <= r_cnt + 3'd1;
                  if (r_cnt == 3'd7)
                     r_rx_done <= 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_accept)
         r_hold <= io_bus.i_tx_data;
      if (w_shift_rx)
         r_rx <= {r_rx[6:0], w_mosi};
      if (w_load)
         r_tx <= w_load_data;
      else if (w_shift_tx)
         r_tx <= {r_tx[6:0], 1'b0};
   end
endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: directed table, hand-written corner sequences and
// randomized transfers against a transaction-level holding-register model.
`timescale 1ns/1ps
module tb_spi_responder;
   localparam int SS = 2;
   localparam int H  = 8;

   typedef struct {
      logic       pre;
      logic [7:0] pre_d;
      logic [7:0] mosi;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
      int         exp_under;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_responder_if bus();
`ifdef SPI_RESPONDER_UNDERRUN_EN
   logic underrun;
`endif

   spi_responder #(.SYNC_STAGES(SS), .IDLE_FILL(8'hFF)) dut (
      .i_clk  (clk),
      .i_rst  (rst_n),
      .io_bus (bus)
`ifdef SPI_RESPONDER_UNDERRUN_EN
      ,
      .o_underrun (underrun)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] rx_log [256];
   int         rx_n    = 0;
   int         under_n = 0;

   always @(negedge clk) begin
      if (bus.o_rx_valid) begin
         rx_log[rx_n % 256] = bus.o_rx_data;
         rx_n = rx_n + 1;
      end
`ifdef SPI_RESPONDER_UNDERRUN_EN
      if (underrun) under_n = under_n + 1;
`endif
   end

   // Transaction-level model: one-entry holding register.
   logic       m_full;
   logic [7:0] m_hold;

   logic [7:0] mo [4];
   logic [7:0] pd [4];
   logic [7:0] mi [4];
   logic [7:0] rx [4];
   logic [7:0] em [4];
   logic [3:0] push;
   int         rxc, und, eu;
   vec_t       tbl [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic preload(input logic [7:0] d);
      check("preload_ready", bus.o_tx_ready, 1);
      bus.i_tx_data  = d;
      bus.i_tx_valid = 1'b1;
      wait_clk(1);
      bus.i_tx_valid = 1'b0;
      check("preload_taken", bus.o_tx_ready, 0);
      m_hold = d;
      m_full = 1'b1;
   endtask

   task automatic bits(input logic [7:0] d, input int cnt, input logic p,
                       input logic [7:0] pdv, input logic last, output logic [7:0] m);
      logic [2:0] idx;
      m = 8'h00;
      for (int j = 0; j < cnt; j++) begin
         idx = 3'(7 - j);
         bus.i_mosi = d[idx];
         if (p && j == 3) begin
            check("push_ready", bus.o_tx_ready, 1);
            bus.i_tx_data  = pdv;
            bus.i_tx_valid = 1'b1;
            wait_clk(1);
            bus.i_tx_valid = 1'b0;
            wait_clk(H - 1);
         end else begin
            wait_clk(H);
         end
         m[idx] = bus.o_miso;
         bus.i_sclk = 1'b1;
         wait_clk(H);
         bus.i_sclk = 1'b0;
         if (last && j == cnt - 1) bus.i_cs_n = 1'b1;
      end
   endtask

   task automatic model_xfer(input int n);
      eu = 0;
      for (int k = 0; k < n; k++) begin
         em[k] = m_full ? m_hold : 8'hFF;
         if (!m_full) eu++;
         m_full = 1'b0;
         if (push[k]) begin
            m_hold = pd[k];
            m_full = 1'b1;
         end
      end
   endtask

   task automatic run(input int n);
      int rx0, u0;
      rx0 = rx_n;
      u0  = under_n;
      bus.i_cs_n = 1'b0;
      for (int k = 0; k < n; k++)
         bits(mo[k], 8, push[k], pd[k], (k == n - 1), mi[k]);
      wait_clk(H);
      rxc = rx_n - rx0;
      for (int k = 0; k < 4; k++)
         rx[k] = (k < rxc) ? rx_log[(rx0 + k) % 256] : 8'h00;
      und = under_n - u0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},     bus.o_miso, 1);
      check({tag, "_ready"},    bus.o_tx_ready, 1);
      check({tag, "_rx_data"},  bus.o_rx_data, 0);
      check({tag, "_rx_valid"}, bus.o_rx_valid, 0);
      check({tag, "_busy"},     bus.o_busy, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] prev_rx;
      logic [7:0] junk;
      int         rx0, n;

      tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
      tbl[1] = '{1'b0, 8'h00, 8'h42, 8'hFF, 8'h42, 1};
      tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
      tbl[3] = '{1'b0, 8'h00, 8'h81, 8'hFF, 8'h81, 1};

      rst_n = 1'b0;
      bus.i_cs_n = 1'b1;
      bus.i_sclk = 1'b0;
      bus.i_mosi = 1'b0;
      bus.i_tx_data  = 8'h00;
      bus.i_tx_valid = 1'b0;
      m_full = 1'b0;
      m_hold = 8'h00;
      push = 4'b0000;
      for (int k = 0; k < 4; k++) begin mo[k] = 8'h00; pd[k] = 8'h00; end

      wait_clk(4);
      check_reset_outputs("rst_held");
      rst_n = 1'b1;
      wait_clk(3);
      check_reset_outputs("rst_rel");

      for (int i = 0; i < 4; i++) begin
         if (tbl[i].pre) preload(tbl[i].pre_d);
         mo[0] = tbl[i].mosi;
         push  = 4'b0000;
         model_xfer(1);
         run(1);
         check("tbl_miso", mi[0], tbl[i].exp_miso);
         check("tbl_rx_cnt", rxc, 1);
         check("tbl_rx", rx[0], tbl[i].exp_rx);
         check("tbl_rx_data", bus.o_rx_data, tbl[i].exp_rx);
         check("tbl_ready", bus.o_tx_ready, 1);
         check("tbl_busy", bus.o_busy, 0);
         check("tbl_idle_miso", bus.o_miso, 1);
`ifdef SPI_RESPONDER_UNDERRUN_EN
         check("tbl_underrun", und, tbl[i].exp_under);
`endif
      end

      // Back-to-back bytes with a refill during the first byte.
      preload(8'h11);
      mo[0] = 8'h01; mo[1] = 8'h80;
      pd[0] = 8'h22;
      push  = 4'b0001;
      model_xfer(2);
      run(2);
      check("b2b_miso0", mi[0], 8'h11);
      check("b2b_miso1", mi[1], 8'h22);
      check("b2b_rx_cnt", rxc, 2);
      check("b2b_rx0", rx[0], 8'h01);
      check("b2b_rx1", rx[1], 8'h80);
`ifdef SPI_RESPONDER_UNDERRUN_EN
      check("b2b_underrun", und, 0);
`endif

      // Abort after 5 rises: partial byte dropped, loaded tx byte lost.
      preload(8'h5A);
      prev_rx = bus.o_rx_data;
      rx0 = rx_n;
      bus.i_cs_n = 1'b0;
      m_full = 1'b0;
      bits(8'hC3, 5, 1'b0, 8'h00, 1'b0, junk);
      check("abort_partial_miso", 32'(junk[7:3]), 32'(5'b01011));
      wait_clk(H);
      bus.i_cs_n = 1'b1;
      wait_clk(2 * H);
      check("abort_no_valid", rx_n - rx0, 0);
      check("abort_rx_data", bus.o_rx_data, prev_rx);
      check("abort_busy", bus.o_busy, 0);
      check("abort_miso", bus.o_miso, 1);
      check("abort_ready", bus.o_tx_ready, 1);
      mo[0] = 8'h99; push = 4'b0000;
      model_xfer(1);
      run(1);
      check("post_abort_miso", mi[0], 8'hFF);
      check("post_abort_rx", rx[0], 8'h99);
      check("post_abort_rx_cnt", rxc, 1);

      // Reset mid-byte while the holding register is full.
      preload(8'h77);
      bus.i_cs_n = 1'b0;
      bits(8'hF0, 6, 1'b1, 8'h88, 1'b0, junk);
      check("pre_rst_ready", bus.o_tx_ready, 0);
      rst_n = 1'b0;
      bus.i_cs_n = 1'b1;
      bus.i_sclk = 1'b0;
      bus.i_mosi = 1'b0;
      wait_clk(1);
      check_reset_outputs("mid_rst");
      m_full = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);
      mo[0] = 8'h5C; push = 4'b0000;
      model_xfer(1);
      run(1);
      check("post_rst_miso", mi[0], 8'hFF);
      check("post_rst_rx", rx[0], 8'h5C);

      // Randomized transfers against the model.
      for (int it = 0; it < 25; it++) begin
         n = int'($urandom_range(1, 3));
         for (int k = 0; k < 4; k++) begin
            mo[k] = 8'($urandom);
            pd[k] = 8'($urandom);
            push[k] = (k < n) ? 1'($urandom) : 1'b0;
         end
         if (!m_full && $urandom_range(0, 1) == 1) preload(8'($urandom));
         model_xfer(n);
         run(n);
         for (int k = 0; k < n; k++) begin
            check("rnd_miso", mi[k], em[k]);
            check("rnd_rx", rx[k], mo[k]);
         end
         check("rnd_rx_cnt", rxc, n);
         check("rnd_ready", bus.o_tx_ready, !m_full);
`ifdef SPI_RESPONDER_UNDERRUN_EN
         check("rnd_underrun", und, eu);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/spi_responder.md
# spi_responder

Mode-0 SPI responder (slave) clocked from the system clock. It is the far end of the core's SPI master port (`o_sclk`/`o_mosi`/`i_miso`), used as a bench model and as an FPGA-side peripheral for loop-back. It oversamples the incoming SCLK, CS_N and MOSI, shifts bytes MSB-first in both directions, and exposes a one-byte transmit holding register and a received-byte strobe.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizers on `i_sclk`, `i_mosi` and `i_cs_n`. Minimum 2.
- `IDLE_FILL`, default 8'hFF: byte shifted out when the holding register is empty at byte start.

Ports:
- `i_clk`, input, 1: system clock. One clock; all logic is on its rising edge.
- `i_rst`, input, 1: reset. Synchronous and active-low.
- `i_cs_n`, input, 1: chip select, active-low, asynchronous to `i_clk`.
- `i_sclk`, input, 1: SPI clock from the master, asynchronous to `i_clk`.
- `i_mosi`, input, 1: master-out data, asynchronous to `i_clk`.
- `o_miso`, output, 1: master-in data, registered.
- `i_tx_data`, input, 8: next byte to send.
- `i_tx_valid`, input, 1: `i_tx_data` valid.
- `o_tx_ready`, output, 1: holding register empty. Transfer occurs when valid && ready.
- `o_rx_data`, output, 8: last complete received byte. Held until the next byte completes.
- `o_rx_valid`, output, 1: one-cycle pulse when `o_rx_data` updates. There is no backpressure.
- `o_busy`, output, 1: synchronized CS_N is low.

## Operation
- **Synchronizers and edge detection:** each async input passes through `SYNC_STAGES` flops. Edge detection compares the last synchronized SCLK against its previous value. A rising edge samples MOSI; a falling edge shifts MISO.
- **State IDLE** (sync CS_N high):
  - `o_miso`=1, bit counter=0, shifter inactive.
  - On sync CS_N falling, go to ACTIVE and load the shifter.
- **Load:** the shifter takes the holding register if it is full, emptying it and raising `o_tx_ready` the next cycle. Otherwise it takes `IDLE_FILL`. `o_miso` is driven with shifter[7] the next cycle.
- **State ACTIVE:**
  - Each SCLK rise: rx shift register takes `{rx[6:0], mosi}` and the bit counter increments modulo 8.
  - Each SCLK fall: tx shifter shifts left and `o_miso` is driven with the new bit 7. The exception is the fall following bit 7, which performs a Load for the next byte instead.
  - When the counter wraps 7→0 on a rising edge, the next cycle gives `o_rx_data` = the completed byte and `o_rx_valid`=1 for one cycle.
- **CS_N rise mid-byte:** return to IDLE. The partial rx byte is discarded with no `o_rx_valid`. The tx byte already loaded is lost, and the holding register is unaffected.
- **Simultaneous events:**
  - A load and a handshake in the same cycle: the load sees the pre-cycle holding state, so an empty register gives `IDLE_FILL`, and the accepted byte is kept for the next byte.
  - An SCLK edge in the same cycle as sync CS_N rise: the CS_N rise wins and the edge is ignored.
- **Reset values:** `o_miso`=1, `o_tx_ready`=1, `o_rx_data`=0, `o_rx_valid`=0, `o_busy`=0, holding register empty, synchronizers at CS_N=1, SCLK=0, MOSI=0, state IDLE.

## Timing
- Input-to-action latency is `SYNC_STAGES`+1 `i_clk` cycles.
- Requirements on the master:
  - SCLK high and low phases each ≥ `SYNC_STAGES`+3 `i_clk` cycles.
  - CS_N fall to first SCLK rise ≥ `SYNC_STAGES`+3 cycles.
  - MOSI stable ≥ 1 `i_clk` cycle before and after the SCLK rise at the pins.
- `o_miso` updates `SYNC_STAGES`+2 cycles after the SCLK fall or CS_N fall at the pins.
- `o_rx_valid` asserts `SYNC_STAGES`+2 cycles after the 8th SCLK rise.
- Back-to-back bytes under one CS_N are supported with no gap.

## Configuration
- `SPI_RESPONDER_UNDERRUN_EN` defined:
  - Adds output `o_underrun` (1 bit, reset 0).
  - It pulses for one cycle in the same cycle that a Load takes `IDLE_FILL` because the holding register was empty.
- Not defined: the port and its logic are absent. Fill behaviour is unchanged.

## Test plan
- Reset held 4 cycles, then released → all outputs at the reset values, `o_tx_ready`=1, `o_miso`=1.
- Preload 0xA5, then CS_N low and master sends 0x3C with 8 mode-0 clocks (half period 8 `i_clk`) → MISO bits 1,0,1,0,0,1,0,1; one `o_rx_valid` pulse with `o_rx_data`=0x3C; `o_tx_ready` rises after the CS_N-fall load.
- No preload, master sends 0x42 → MISO returns 0xFF; `o_rx_data`=0x42; with the macro defined, exactly one `o_underrun` pulse.
- Two back-to-back bytes 0x01, 0x80 under one CS_N, with 0x11 preloaded and 0x22 accepted during byte 1 → MISO returns 0x11 then 0x22; two `o_rx_valid` pulses with 0x01 then 0x80.
- CS_N raised after 5 SCLK rises → no `o_rx_valid`, `o_rx_data` unchanged, `o_busy` falls, `o_miso`=1; the next full transfer is received correctly.
- `i_rst` asserted mid-byte with a held byte → all outputs return to reset values next cycle; holding register empty; the subsequent transfer returns 0xFF.
